// File: rtl/tt_um_jimktrains_vslc_instr_fifo.sv
// Instruction byte FIFO between the SPI EEPROM reader and the executor.
// It parses the program header, throttles the reader via HOLD#, and re-arms it at end of program.
module tt_um_jimktrains_vslc_instr_fifo #(
  parameter int DEPTH       = 4,
  parameter int HOLD_MARGIN = 1,
  parameter int ADDR_W      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_ready,
  input  logic [7:0]               rd_byte,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [7:0]               instr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic                     hold_n,
  output logic                     restart,
  output logic                     scan_done,
  output logic [ADDR_W-1:0]        start_addr,
  output logic [ADDR_W-1:0]        end_addr,
  output logic                     hdr_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_HEADER, S_RUN, S_RESTART, S_RESYNC} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [ADDR_W-1:0]  r_start_addr, r_end_addr;
  logic               r_hdr_valid, r_overflow, r_hold_n;
  logic               w_push_req, w_end_hit, w_full, w_pop, w_push;

  // end_addr == 0 means the program loops forever without a restart
  assign w_end_hit = (r_end_addr != '0) && (rd_addr >= r_end_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HEADER;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    case (r_state)
      S_HEADER:  if (rd_ready && rd_addr == ADDR_W'(3)) w_state_nxt = S_RUN;
      S_RUN: begin
        if (rd_ready) begin
          w_push_req = 1'b1;
          if (w_end_hit) w_state_nxt = S_RESTART;
        end
      end
      S_RESTART: w_state_nxt = S_RESYNC;
      S_RESYNC: begin
        if (rd_ready && rd_addr == r_start_addr) begin
          w_push_req  = 1'b1;
          w_state_nxt = w_end_hit ? S_RESTART : S_RUN;
        end
      end
      default:   w_state_nxt = S_HEADER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_hdr_valid  <= 1'b0;
    end else if (r_state == S_HEADER && rd_ready) begin
      case (rd_addr)
        ADDR_W'(0): r_start_addr[ADDR_W-1:8] <= rd_byte[ADDR_W-9:0];
        ADDR_W'(1): r_start_addr[7:0]        <= rd_byte;
        ADDR_W'(2): r_end_addr[ADDR_W-1:8]   <= rd_byte[ADDR_W-9:0];
        ADDR_W'(3): begin
          r_end_addr[7:0] <= rd_byte;
          r_hdr_valid     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // a pop frees the slot in the same cycle, so push+pop is legal when full
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_pop       = (r_count != '0) && instr_ready;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_hold_n   <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= rd_byte;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count  <= w_count_nxt;
      r_hold_n <= !(w_count_nxt >= CNT_W'(DEPTH - HOLD_MARGIN));
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_mem[r_rptr] : 8'h00;
  assign hold_n      = r_hold_n;
  assign restart     = (r_state == S_RESTART);
  assign scan_done   = (r_state == S_RESTART);
  assign start_addr  = r_start_addr;
  assign end_addr    = r_end_addr;
  assign hdr_valid   = r_hdr_valid;
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule
